// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, reset constants and state encoding for the fetch stage
// Purpose: constants and helpers imported by the fetch/IF-ID stage, its interface and PC register.
// Ports: none (package).
package cpu_pkg;

   localparam int PC_WIDTH    = 16;
   localparam int INSTR_WIDTH = 16;

   localparam logic [PC_WIDTH-1:0]    RESET_PC  = 16'h0000;
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0000;

   localparam logic [0:0] STATE_RUN    = 1'b0;
   localparam logic [0:0] STATE_HALTED = 1'b1;

   // Instructions are half-word aligned, so a redirect target never keeps bit 0.
   function automatic logic [PC_WIDTH-1:0] align_half(input logic [PC_WIDTH-1:0] addr);
      return {addr[PC_WIDTH-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_if_id_stage_if.sv
// rtl/fetch_if_id_stage_if.sv - fetch-stage bus: instruction memory, hazard/branch controls, IF/ID outputs
// Purpose: bundles every non-clock signal of fetch_if_id_stage.
// Ports (master = the stage):
//   if_from_pc out, if_instruction in          instruction memory address / read data
//   stall, branch_taken, branch_target, flush, halt in   hazard, branch and control inputs
//   id_instruction, id_pc, id_pc_plus2, id_valid, halted out   IF/ID buffer and state
interface fetch_if_id_stage_if;
   import cpu_pkg::*;

   logic [PC_WIDTH-1:0]    if_from_pc;
   logic [INSTR_WIDTH-1:0] if_instruction;
   logic                   stall;
   logic                   branch_taken;
   logic [PC_WIDTH-1:0]    branch_target;
   logic                   flush;
   logic                   halt;
   logic [INSTR_WIDTH-1:0] id_instruction;
   logic [PC_WIDTH-1:0]    id_pc;
   logic [PC_WIDTH-1:0]    id_pc_plus2;
   logic                   id_valid;
   logic                   halted;

   modport master (
      output if_from_pc,
      input  if_instruction,
      input  stall,
      input  branch_taken,
      input  branch_target,
      input  flush,
      input  halt,
      output id_instruction,
      output id_pc,
      output id_pc_plus2,
      output id_valid,
      output halted
   );

   modport slave (
      input  if_from_pc,
      output if_instruction,
      output stall,
      output branch_taken,
      output branch_target,
      output flush,
      output halt,
      input  id_instruction,
      input  id_pc,
      input  id_pc_plus2,
      input  id_valid,
      input  halted
   );

endinterface

// File: rtl/fetch_if_id_stage_pc_register.sv
// rtl/fetch_if_id_stage_pc_register.sv - program counter with next-PC selection, alignment and increment
// Purpose: holds the PC; priority reset > halted hold > branch redirect > stall hold > increment.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   halted                stage is halted: PC frozen
//   branch_taken/target   redirect request and address (bit 0 dropped)
//   stall                 hold PC
//   pc                    registered PC
//   pc_plus_step          pc + STEP, wrapping modulo 2^PC_WIDTH
module pc_register
   import cpu_pkg::*;
#(
   parameter int STEP = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                halted,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                stall,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] pc_plus_step
);

   localparam logic [PC_WIDTH-1:0] STEP_V = PC_WIDTH'(STEP);

   // Truncation to PC_WIDTH gives the silent wrap from the top of the address space.
   assign pc_plus_step = pc + STEP_V;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (halted) begin
         pc <= pc;
      end else if (branch_taken) begin
         pc <= align_half(branch_target);
      end else if (stall) begin
         pc <= pc;
      end else begin
         pc <= pc_plus_step;
      end
   end

endmodule

// File: rtl/fetch_if_id_stage.sv
// rtl/fetch_if_id_stage.sv - fetch stage: PC, IF/ID pipeline buffer and RUN/HALTED state
// Purpose: presents the PC to instruction memory and captures instruction, PC and PC+step for decode.
// Ports:
//   clk    system clock, rising-edge updates
//   reset  synchronous active-high reset
//   bus    fetch_if_id_stage_if.master (memory, hazard/branch controls, IF/ID outputs, halted)
module fetch_if_id_stage
   import cpu_pkg::*;
#(
   parameter int PC_STEP = 2
) (
   input  logic                clk,
   input  logic                reset,
   fetch_if_id_stage_if.master bus
);

   logic [0:0]          state;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_plus_step;
   logic                is_halted;

   assign is_halted = (state == STATE_HALTED);

   pc_register #(
      .STEP (PC_STEP)
   ) u_pc_register (
      .clk           (clk),
      .reset         (reset),
      .halted        (is_halted),
      .branch_taken  (bus.branch_taken),
      .branch_target (bus.branch_target),
      .stall         (bus.stall),
      .pc            (pc),
      .pc_plus_step  (pc_plus_step)
   );

   assign bus.if_from_pc = pc;
   assign bus.halted     = is_halted;

   // HALTED is sticky; only reset returns to RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= STATE_RUN;
      end else if (bus.halt) begin
         state <= STATE_HALTED;
      end
   end

   // A taken branch bubbles the buffer even under stall so the wrong-path fetch never reaches decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.id_instruction <= NOP_INSTR;
         bus.id_pc          <= '0;
         bus.id_pc_plus2    <= '0;
         bus.id_valid       <= 1'b0;
      end else if (bus.flush || bus.branch_taken) begin
         bus.id_instruction <= NOP_INSTR;
         bus.id_valid       <= 1'b0;
      end else if (bus.stall) begin
         bus.id_valid       <= bus.id_valid;
      end else if (is_halted) begin
         bus.id_instruction <= NOP_INSTR;
         bus.id_valid       <= 1'b0;
      end else begin
         bus.id_instruction <= bus.if_instruction;
         bus.id_pc          <= pc;
         bus.id_pc_plus2    <= pc_plus_step;
         bus.id_valid       <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// tb/tb_fetch_if_id_stage.sv - directed table-driven bench for fetch_if_id_stage
module tb_fetch_if_id_stage;

   logic clk;
   logic reset;

   fetch_if_id_stage_if bus ();

   fetch_if_id_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: word at address a is 16'hA000 + a.
   assign bus.if_instruction = 16'hA000 + bus.if_from_pc;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        br;
      logic [15:0] tgt;
      logic        flush;
      logic        halt;
      logic [15:0] e_pc;
      logic [15:0] e_ins;
      logic [15:0] e_idpc;
      logic [15:0] e_p2;
      logic        e_v;
      logic        e_h;
   } vec_t;

   vec_t vecs[$];
   int   passed = 0;
   int   total  = 0;

   task automatic add(input logic rst, input logic stall, input logic br, input logic [15:0] tgt,
                      input logic flush, input logic halt,
                      input logic [15:0] e_pc, input logic [15:0] e_ins, input logic [15:0] e_idpc,
                      input logic [15:0] e_p2, input logic e_v, input logic e_h);
      vec_t v;
      v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt; v.flush = flush; v.halt = halt;
      v.e_pc = e_pc; v.e_ins = e_ins; v.e_idpc = e_idpc; v.e_p2 = e_p2; v.e_v = e_v; v.e_h = e_h;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic drive(input logic rst, input logic stall, input logic br, input logic [15:0] tgt,
                        input logic flush, input logic halt);
      reset             = rst;
      bus.stall         = stall;
      bus.branch_taken  = br;
      bus.branch_target = tgt;
      bus.flush         = flush;
      bus.halt          = halt;
   endtask

   initial begin
      //   rst st br tgt      fl ht   pc       ins      id_pc    pc+2     v  h
      add(1, 0, 0, 16'h0000, 0, 0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0); // reset
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0002, 16'hA000, 16'h0000, 16'h0002, 1, 0);
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0004, 16'hA002, 16'h0002, 16'h0004, 1, 0);
      add(0, 1, 0, 16'h0000, 0, 0,  16'h0004, 16'hA002, 16'h0002, 16'h0004, 1, 0); // stall x2
      add(0, 1, 0, 16'h0000, 0, 0,  16'h0004, 16'hA002, 16'h0002, 16'h0004, 1, 0);
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0006, 16'hA004, 16'h0004, 16'h0006, 1, 0); // resume
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0008, 16'hA006, 16'h0006, 16'h0008, 1, 0);
      add(0, 1, 1, 16'h0101, 0, 0,  16'h0100, 16'h0000, 16'h0006, 16'h0008, 0, 0); // branch+stall
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0102, 16'hA100, 16'h0100, 16'h0102, 1, 0);
      add(0, 0, 1, 16'hFFFF, 0, 0,  16'hFFFE, 16'h0000, 16'h0100, 16'h0102, 0, 0); // to FFFE
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0000, 16'h9FFE, 16'hFFFE, 16'h0000, 1, 0); // wrap
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0002, 16'hA000, 16'h0000, 16'h0002, 1, 0);
      add(0, 0, 1, 16'h000A, 0, 0,  16'h000A, 16'h0000, 16'h0000, 16'h0002, 0, 0); // to 10
      add(0, 0, 0, 16'h0000, 0, 1,  16'h000C, 16'hA00A, 16'h000A, 16'h000C, 1, 1); // halt
      add(0, 0, 0, 16'h0000, 0, 0,  16'h000C, 16'h0000, 16'h000A, 16'h000C, 0, 1); // sticky
      add(0, 0, 1, 16'h0200, 0, 0,  16'h000C, 16'h0000, 16'h000A, 16'h000C, 0, 1); // branch ignored
      add(1, 0, 0, 16'h0000, 0, 0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0); // reset exits
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0002, 16'hA000, 16'h0000, 16'h0002, 1, 0);
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0004, 16'hA002, 16'h0002, 16'h0004, 1, 0);
      add(0, 1, 0, 16'h0000, 1, 0,  16'h0004, 16'h0000, 16'h0002, 16'h0004, 0, 0); // flush+stall
      add(1, 1, 1, 16'h0300, 1, 1,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0); // reset wins
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0002, 16'hA000, 16'h0000, 16'h0002, 1, 0);
      add(0, 0, 1, 16'h0300, 0, 1,  16'h0300, 16'h0000, 16'h0000, 16'h0002, 0, 1); // halt+branch
      add(0, 0, 0, 16'h0000, 0, 0,  16'h0300, 16'h0000, 16'h0000, 16'h0002, 0, 1);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].flush, vecs[i].halt);
         @(posedge clk);
         @(negedge clk);
         chk("if_from_pc",     i, bus.if_from_pc,         vecs[i].e_pc);
         chk("id_instruction", i, bus.id_instruction,     vecs[i].e_ins);
         chk("id_pc",          i, bus.id_pc,              vecs[i].e_idpc);
         chk("id_pc_plus2",    i, bus.id_pc_plus2,        vecs[i].e_p2);
         chk("id_valid",       i, {15'd0, bus.id_valid},  {15'd0, vecs[i].e_v});
         chk("halted",         i, {15'd0, bus.halted},    {15'd0, vecs[i].e_h});
      end

      // Halted with stall and flush toggling for several cycles: PC never moves, nothing valid.
      for (int k = 0; k < 5; k++) begin
         drive(0, k[0], 0, 16'h0000, k[1], 0);
         @(posedge clk);
         @(negedge clk);
         chk("halt_hold_pc",     100 + k, bus.if_from_pc,        16'h0300);
         chk("halt_hold_valid",  100 + k, {15'd0, bus.id_valid}, 16'h0000);
         chk("halt_hold_halted", 100 + k, {15'd0, bus.halted},   16'h0001);
      end

      // Reset, then a long stall followed by release: each fetch address appears exactly once in id_pc.
      drive(1, 0, 0, 16'h0000, 0, 0);
      @(posedge clk);
      @(negedge clk);
      chk("restart_pc", 200, bus.if_from_pc, 16'h0000);
      drive(0, 0, 0, 16'h0000, 0, 0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1, 0, 16'h0000, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("long_stall_pc",    210 + k, bus.if_from_pc, 16'h0002);
         chk("long_stall_id_pc", 210 + k, bus.id_pc,      16'h0000);
      end
      drive(0, 0, 0, 16'h0000, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("release_id_pc",  220 + k, bus.id_pc,          16'(2 * (k + 1)));
         chk("release_id_ins", 220 + k, bus.id_instruction, 16'hA000 + 16'(2 * (k + 1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
